// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_seq_ctrl
// Description : Sequencer for the calculator datapath. On an equals-key edge
//               it starts the infix-to-postfix converter, waits for it, starts
//               the postfix evaluator, waits for it, and then presents a
//               DONE/ERR result until the consumer acknowledges it. Each wait
//               is bounded by TIMEOUT cycles and every run is timed.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_seq_ctrl #(
    parameter int depth   = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       ack,
    input  logic [$clog2(depth+1)-1:0] infixSize,
    input  logic                       convDone,
    input  logic [$clog2(depth+1)-1:0] postfixSize,
    input  logic                       evalDone,
    input  logic                       evalError,
    output logic                       conv,
    output logic                       evalStart,
    output logic [$clog2(depth+1)-1:0] evalLen,
    output logic                       busy,
    output logic                       resultValid,
    output logic [1:0]                 errCode,
    output logic [15:0]                runCycles
);

    // The wait counter only has to represent 0..TIMEOUT-1: the cycle in which
    // it would reach TIMEOUT is the cycle that raises the timeout.
    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CONV      = 3'd1;
    localparam logic [2:0] S_WAIT_CONV = 3'd2;
    localparam logic [2:0] S_EVAL      = 3'd3;
    localparam logic [2:0] S_WAIT_EVAL = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_ERR       = 3'd6;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_EMPTY   = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] c_ERR_EVAL    = 2'b11;

    logic [2:0]          r_state;
    logic                r_start;
    logic [c_WAIT_W-1:0] r_wait;
    logic [15:0]         r_run;

    logic                w_start_edge;
    logic                w_wait_expired;
    logic [15:0]         w_run_inc;

    assign w_start_edge   = start & ~r_start;
    assign w_wait_expired = (r_wait == c_WAIT_LAST);
    // Busy-cycle count including the current cycle, pinned at FFFF.
    assign w_run_inc      = (r_run == 16'hFFFF) ? r_run : r_run + 16'd1;

    // Sequencer: state, counters and every output are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_start     <= 1'b0;
            r_wait      <= '0;
            r_run       <= '0;
            conv        <= 1'b0;
            evalStart   <= 1'b0;
            evalLen     <= '0;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            errCode     <= c_ERR_NONE;
            runCycles   <= '0;
        end else begin
            r_start   <= start;
            // Pulses last exactly one cycle, which also guarantees the
            // converter sees a low cycle between two start pulses.
            conv      <= 1'b0;
            evalStart <= 1'b0;

            if (abort && (r_state != S_IDLE)) begin
                // Abort beats done pulses, timeouts and ack; the last run
                // time is left as it was.
                r_state     <= S_IDLE;
                busy        <= 1'b0;
                resultValid <= 1'b0;
                errCode     <= c_ERR_NONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_edge) begin
                            r_run <= '0;
                            if (infixSize == '0) begin
                                r_state   <= S_ERR;
                                errCode   <= c_ERR_EMPTY;
                                runCycles <= '0;
                            end else begin
                                r_state <= S_CONV;
                                conv    <= 1'b1;
                                busy    <= 1'b1;
                            end
                        end
                    end

                    S_CONV: begin
                        r_state <= S_WAIT_CONV;
                        r_wait  <= '0;
                        r_run   <= w_run_inc;
                    end

                    S_WAIT_CONV: begin
                        r_run <= w_run_inc;
                        if (convDone) begin
                            evalLen <= postfixSize;
                            if (postfixSize == '0) begin
                                r_state   <= S_ERR;
                                errCode   <= c_ERR_EMPTY;
                                busy      <= 1'b0;
                                runCycles <= w_run_inc;
                            end else begin
                                r_state   <= S_EVAL;
                                evalStart <= 1'b1;
                            end
                        end else if (w_wait_expired) begin
                            r_state   <= S_ERR;
                            errCode   <= c_ERR_TIMEOUT;
                            busy      <= 1'b0;
                            runCycles <= w_run_inc;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end

                    S_EVAL: begin
                        r_state <= S_WAIT_EVAL;
                        r_wait  <= '0;
                        r_run   <= w_run_inc;
                    end

                    S_WAIT_EVAL: begin
                        r_run <= w_run_inc;
                        if (evalDone) begin
                            busy      <= 1'b0;
                            runCycles <= w_run_inc;
                            if (evalError) begin
                                r_state <= S_ERR;
                                errCode <= c_ERR_EVAL;
                            end else begin
                                r_state     <= S_DONE;
                                resultValid <= 1'b1;
                            end
                        end else if (w_wait_expired) begin
                            r_state   <= S_ERR;
                            errCode   <= c_ERR_TIMEOUT;
                            busy      <= 1'b0;
                            runCycles <= w_run_inc;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end

                    S_DONE, S_ERR: begin
                        // A start edge here is consumed by r_start, so a run
                        // needs a fresh edge once back in IDLE.
                        if (ack) begin
                            r_state     <= S_IDLE;
                            resultValid <= 1'b0;
                            errCode     <= c_ERR_NONE;
                        end
                    end

                    default: begin
                        r_state     <= S_IDLE;
                        busy        <= 1'b0;
                        resultValid <= 1'b0;
                        errCode     <= c_ERR_NONE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_seq_ctrl
// Description : Self-checking bench for calc_seq_ctrl: a table of directed
//               runs, hand-written corner sequences (timeout edge, abort,
//               reset mid-run) and randomized runs scored against a
//               run-level model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_seq_ctrl;

    localparam int TMO = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       ack;
    logic [3:0] infixSize;
    logic       convDone;
    logic [3:0] postfixSize;
    logic       evalDone;
    logic       evalError;
    logic       conv;
    logic       evalStart;
    logic [3:0] evalLen;
    logic       busy;
    logic       resultValid;
    logic [1:0] errCode;
    logic [15:0] runCycles;

    int n_checks = 0;
    int n_fail   = 0;
    int n_conv   = 0;
    int n_eval   = 0;
    int n_conv_double = 0;
    logic prev_conv = 1'b0;
    int exp_last_run = 0;

    calc_seq_ctrl #(.depth(10), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .ack        (ack),
        .infixSize  (infixSize),
        .convDone   (convDone),
        .postfixSize(postfixSize),
        .evalDone   (evalDone),
        .evalError  (evalError),
        .conv       (conv),
        .evalStart  (evalStart),
        .evalLen    (evalLen),
        .busy       (busy),
        .resultValid(resultValid),
        .errCode    (errCode),
        .runCycles  (runCycles)
    );

    always #5 clock = ~clock;

    // Pulse monitor: counts converter/evaluator start pulses and flags a conv
    // that stays high for two consecutive cycles.
    always @(negedge clock) begin
        if (conv) n_conv++;
        if (evalStart) n_eval++;
        if (conv && prev_conv) n_conv_double++;
        prev_conv = conv;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int infix;
        int cd;        // WAIT_CONV cycles that pass before convDone arrives
        int ps;
        int ed;        // WAIT_EVAL cycles that pass before evalDone arrives
        int ee;
        int edge_ack;  // release with a fresh start edge in the ack cycle
        int exp_err;
        int exp_valid;
        int exp_run;
        int exp_len;   // -1: evalLen not checked
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Run-level reference: the outcome of one evaluation request follows
    // directly from which stage finishes first and how long each wait lasts.
    function automatic vec_t model(input int infix, input int cd, input int ps,
                                   input int ed, input int ee, input int ea);
        vec_t v;
        v.infix = infix; v.cd = cd; v.ps = ps; v.ed = ed; v.ee = ee;
        v.edge_ack = ea;
        v.exp_valid = 0;
        v.exp_len = -1;
        if (infix == 0) begin
            v.exp_err = 1;
            v.exp_run = 0;
        end else if (cd >= TMO) begin
            v.exp_err = 2;
            v.exp_run = 1 + TMO;
        end else begin
            v.exp_len = ps;
            if (ps == 0) begin
                v.exp_err = 1;
                v.exp_run = 1 + (cd + 1);
            end else if (ed >= TMO) begin
                v.exp_err = 2;
                v.exp_run = 1 + (cd + 1) + 1 + TMO;
            end else begin
                v.exp_run   = 1 + (cd + 1) + 1 + (ed + 1);
                v.exp_err   = (ee != 0) ? 3 : 0;
                v.exp_valid = (ee != 0) ? 0 : 1;
            end
        end
        return v;
    endfunction

    task automatic do_run(input vec_t v, input string tag);
        int c0;
        int e0;
        int exp_nconv;
        int exp_neval;
        exp_nconv = (v.infix != 0) ? 1 : 0;
        exp_neval = (v.infix != 0 && v.cd < TMO && v.ps != 0) ? 1 : 0;
        // Idle cycle with stray done pulses, which IDLE must ignore.
        start = 1'b0; convDone = 1'b1; evalDone = 1'b1;
        tick();
        convDone = 1'b0; evalDone = 1'b0;
        check({tag, " idle_busy"}, int'(busy), 0);
        c0 = n_conv; e0 = n_eval;
        infixSize = 4'(v.infix);
        start = 1'b1;
        tick();
        if (v.infix != 0) begin
            tick();
            for (int i = 0; i < v.cd && i < TMO + 1; i++) tick();
            if (v.cd < TMO) begin
                convDone = 1'b1; postfixSize = 4'(v.ps);
                tick();
                convDone = 1'b0; postfixSize = 4'($urandom_range(0, 10));
                if (v.ps != 0) begin
                    tick();
                    for (int i = 0; i < v.ed && i < TMO + 1; i++) tick();
                    if (v.ed < TMO) begin
                        evalDone = 1'b1; evalError = (v.ee != 0);
                        tick();
                        evalDone = 1'b0; evalError = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
        tick();
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " resultValid"}, int'(resultValid), v.exp_valid);
        check({tag, " errCode"}, int'(errCode), v.exp_err);
        check({tag, " runCycles"}, int'(runCycles), v.exp_run);
        if (v.exp_len >= 0) check({tag, " evalLen"}, int'(evalLen), v.exp_len);
        check({tag, " conv_pulses"}, n_conv - c0, exp_nconv);
        check({tag, " eval_pulses"}, n_eval - e0, exp_neval);
        // Late done pulses while the result is held must change nothing.
        convDone = 1'b1; evalDone = 1'b1; postfixSize = 4'(v.ps + 1);
        tick();
        convDone = 1'b0; evalDone = 1'b0;
        check({tag, " held_errCode"}, int'(errCode), v.exp_err);
        check({tag, " held_valid"}, int'(resultValid), v.exp_valid);
        if (v.exp_len >= 0) check({tag, " held_evalLen"}, int'(evalLen), v.exp_len);
        if (v.edge_ack != 0) begin
            start = 1'b0;
            tick();
            start = 1'b1;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, " ack_errCode"}, int'(errCode), 0);
        check({tag, " ack_valid"}, int'(resultValid), 0);
        // start is still high: no new run until it falls and rises again.
        tick();
        tick();
        check({tag, " no_rerun_busy"}, int'(busy), 0);
        check({tag, " no_rerun_conv"}, n_conv - c0, exp_nconv);
        check({tag, " runCycles_kept"}, int'(runCycles), v.exp_run);
        exp_last_run = v.exp_run;
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        int   c0;
        int   e0;

        //        infix cd  ps  ed  ee  ea  err val run len
        vecs[0] = '{5,   7,  4,  9,  0,  0,  0,  1,  20, 4};
        vecs[1] = '{0,   0,  0,  0,  0,  0,  1,  0,  0,  -1};
        vecs[2] = '{3,   15, 0,  0,  0,  1,  2,  0,  16, -1};
        vecs[3] = '{3,   14, 2,  0,  0,  0,  0,  1,  18, 2};
        vecs[4] = '{4,   2,  0,  0,  0,  1,  1,  0,  4,  0};
        vecs[5] = '{6,   0,  5,  3,  1,  0,  3,  0,  7,  5};
        vecs[6] = '{2,   1,  1,  15, 0,  0,  2,  0,  19, 1};
        vecs[7] = '{10,  0,  10, 14, 0,  1,  0,  1,  18, 10};

        reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
        infixSize = '0; convDone = 1'b0; postfixSize = '0;
        evalDone = 1'b0; evalError = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset conv", int'(conv), 0);
        check("reset evalStart", int'(evalStart), 0);
        check("reset evalLen", int'(evalLen), 0);
        check("reset busy", int'(busy), 0);
        check("reset resultValid", int'(resultValid), 0);
        check("reset errCode", int'(errCode), 0);
        check("reset runCycles", int'(runCycles), 0);

        for (int i = 0; i < 8; i++) do_run(vecs[i], $sformatf("vec%0d", i));

        // Conversion timeout lands exactly TIMEOUT cycles into WAIT_CONV.
        start = 1'b0; tick();
        infixSize = 4'd3; start = 1'b1; tick();
        tick();
        repeat (TMO - 1) tick();
        check("tmo still_busy", int'(busy), 1);
        check("tmo not_yet_err", int'(errCode), 0);
        tick();
        check("tmo errCode", int'(errCode), 2);
        check("tmo busy", int'(busy), 0);
        check("tmo runCycles", int'(runCycles), 1 + TMO);
        exp_last_run = 1 + TMO;
        ack = 1'b1; tick(); ack = 1'b0;
        check("tmo ack_errCode", int'(errCode), 0);

        // Abort coincident with evalDone in WAIT_EVAL.
        start = 1'b0; tick();
        c0 = n_conv; e0 = n_eval;
        infixSize = 4'd3; start = 1'b1; tick();
        tick();
        convDone = 1'b1; postfixSize = 4'd2; tick();
        convDone = 1'b0;
        tick();
        tick(); tick();
        evalDone = 1'b1; evalError = 1'b0; abort = 1'b1; tick();
        evalDone = 1'b0; abort = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort resultValid", int'(resultValid), 0);
        check("abort errCode", int'(errCode), 0);
        check("abort runCycles", int'(runCycles), exp_last_run);
        check("abort conv_pulses", n_conv - c0, 1);
        check("abort eval_pulses", n_eval - e0, 1);
        tick();
        check("abort stays_idle", int'(busy) + int'(resultValid), 0);

        // Randomized runs against the run-level model.
        for (int r = 0; r < 40; r++) begin
            int infix;
            int ps;
            infix = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            ps    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            v = model(infix, int'($urandom_range(0, 17)), ps,
                      int'($urandom_range(0, 17)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0,
                      int'($urandom_range(0, 1)));
            do_run(v, $sformatf("rnd%0d", r));
        end

        // Reset in WAIT_CONV, then a late convDone.
        start = 1'b0; tick();
        infixSize = 4'd4; start = 1'b1; tick();
        tick(); tick(); tick();
        reset = 1'b1; start = 1'b0; tick();
        reset = 1'b0;
        c0 = n_conv; e0 = n_eval;
        check("rst_mid conv", int'(conv), 0);
        check("rst_mid evalStart", int'(evalStart), 0);
        convDone = 1'b1; postfixSize = 4'd5; tick();
        convDone = 1'b0;
        tick();
        check("rst_mid busy", int'(busy), 0);
        check("rst_mid evalLen", int'(evalLen), 0);
        check("rst_mid resultValid", int'(resultValid), 0);
        check("rst_mid errCode", int'(errCode), 0);
        check("rst_mid runCycles", int'(runCycles), 0);
        check("rst_mid pulses", (n_conv - c0) + (n_eval - e0), 0);

        check("conv single_cycle", n_conv_double, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
